// File: rtl/encoder_ltr_pkg.sv
// encoder_ltr_pkg: symbol type, FSM states and the bit-to-symbol mapping rule.
package encoder_ltr_pkg;
    typedef logic signed [31:0] symbol_t;
    typedef enum logic [1:0] {IDLE, SEND, PARITY} state_t;
    function automatic symbol_t map_bit(input logic b, input symbol_t amplitude);
        return b ? -amplitude : amplitude;
    endfunction
endpackage

// File: rtl/encoder_ltr_symbol_mapper.sv
// symbol_mapper: combinational antipodal mapping, 0 -> +AMPLITUDE, 1 -> -AMPLITUDE.
module symbol_mapper
    import encoder_ltr_pkg::*;
#(
    parameter int AMPLITUDE = 1
) (
    input  logic    i_bit,
    output symbol_t o_sym
);
    assign o_sym = map_bit(i_bit, symbol_t'(AMPLITUDE));
endmodule

// File: rtl/encoder_ltr.sv
// encoder_ltr: serialises DATA_WIDTH-bit words into antipodal symbols, bit 0 first.
// Define ENCODER_LTR_PARITY_EN to append an even-parity symbol to every word.
module encoder_ltr
    import encoder_ltr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int AMPLITUDE  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  sym_valid,
    input  logic                  sym_ready,
    output logic signed [31:0]    sym_data,
    output logic                  sym_last,
    output logic                  busy
);
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
    state_t                r_state, w_state_n;
    logic [DATA_WIDTH-1:0] r_shreg, w_shreg_n;
    logic [IW-1:0]         r_idx, w_idx_n;
    logic                  r_valid, r_last, w_last_n, w_hs, w_load, w_bit;
    symbol_t               r_data, w_sym;
`ifdef ENCODER_LTR_PARITY_EN
    logic                  r_par, w_par_n;
`endif
    assign w_hs     = r_valid & sym_ready;
    assign in_ready = (r_state == IDLE) | (w_hs & r_last);
    assign w_load   = in_valid & in_ready;
    // Outputs are registered from the next state so the symbol appears the cycle after acceptance.
    always_comb begin
        w_state_n = r_state;
        w_shreg_n = r_shreg;
        w_idx_n   = r_idx;
`ifdef ENCODER_LTR_PARITY_EN
        w_par_n   = r_par;
`endif
        if (w_load) begin
            w_state_n = SEND;
            w_shreg_n = in_data;
            w_idx_n   = '0;
`ifdef ENCODER_LTR_PARITY_EN
            w_par_n   = ^in_data;
`endif
        end else if (w_hs) begin
            w_shreg_n = r_shreg >> 1;
            w_idx_n   = r_idx + IW'(1);
`ifdef ENCODER_LTR_PARITY_EN
            w_state_n = (r_state == PARITY) ? IDLE : (r_idx == LAST_IDX) ? PARITY : SEND;
`else
            w_state_n = (r_idx == LAST_IDX) ? IDLE : SEND;
`endif
        end
`ifdef ENCODER_LTR_PARITY_EN
        w_last_n = (w_state_n == PARITY);
        w_bit    = (w_state_n == PARITY) ? w_par_n : w_shreg_n[0];
`else
        w_last_n = (w_state_n == SEND) && (w_idx_n == LAST_IDX);
        w_bit    = w_shreg_n[0];
`endif
    end
    symbol_mapper #(.AMPLITUDE(AMPLITUDE)) u_map (.i_bit(w_bit), .o_sym(w_sym));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
`ifdef ENCODER_LTR_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_shreg <= w_shreg_n;
            r_idx   <= w_idx_n;
            r_valid <= (w_state_n != IDLE);
            r_last  <= w_last_n;
            r_data  <= (w_state_n != IDLE) ? w_sym : '0;
`ifdef ENCODER_LTR_PARITY_EN
            r_par   <= w_par_n;
`endif
        end
    end
    assign sym_valid = r_valid;
    assign sym_last  = r_last;
    assign sym_data  = r_data;
    assign busy      = r_valid;
endmodule
